// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter controller and its datapath.
package fir_pkg;

    // Controller phases: wait for a sample, issue tap addresses, let the
    // pipeline empty, then hold the finished result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fir_state_t;

    // Default tap count and address-to-accumulate latency of the datapath.
    localparam int unsigned COEFF_SIZE = 64;
    localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/fir_controller.sv
// FIR filter sequencer: accepts one sample, steps the coefficient counter
// through every tap, tracks each issued address down the ROM/multiplier
// pipeline so the multiplier and accumulator enables line up with it, then
// holds the result until downstream takes it.
module fir_controller
    import fir_pkg::*;
#(
    parameter int unsigned coeff_size = COEFF_SIZE,
    parameter int unsigned pipe_depth = PIPE_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic input_valid,
    output logic input_ready,
    output logic output_valid,
    input  logic output_ready,
    input  logic tc,
    output logic input_reset,
    output logic input_enable,
    output logic output_reset,
    output logic output_enable,
    output logic counter_reset,
    output logic counter_enable,
    output logic multiplier_reset,
    output logic multiplier_enable
);

    localparam int unsigned DCW = $clog2(pipe_depth + 1);

    // The tap count is set by the datapath counter (tc); only sanity-check it.
    if (coeff_size < 1 || pipe_depth < 1) begin : g_param_check
        $error("fir_controller: coeff_size and pipe_depth must both be at least 1");
    end

    fir_state_t            state;
    logic [DCW-1:0]        drain_cnt;
    // issue_dly[i] is set when an address was issued i+1 cycles ago.
    logic [pipe_depth-1:0] issue_dly;
    // issue_tap[d] is set when an address was issued d cycles ago (d=0: now).
    logic [pipe_depth:0]   issue_tap;
    logic                  in_mac;
    logic                  accept;

    assign in_mac    = (state == MAC);
    assign issue_tap = {issue_dly, in_mac};
    assign accept    = reset && !flush && (state == IDLE) && input_valid;

    // Sequencing FSM with the drain-length counter; flush overrides every transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else if (flush) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (tc) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(pipe_depth - 1)) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift a marker for every issued address so downstream enables follow it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_dly <= '0;
        end else if (flush) begin
            issue_dly <= '0;
        end else begin
            issue_dly <= issue_tap[pipe_depth-1:0];
        end
    end

    // Handshake and datapath controls, all decoded from registered state
    // except the accept-cycle strobes that depend on input_valid.
    assign input_ready       = reset && !flush && (state == IDLE);
    assign output_valid      = (state == DONE);
    assign input_enable      = accept;
    assign input_reset       = !reset || flush;
    assign counter_reset     = !reset || flush || accept;
    assign multiplier_reset  = !reset || flush || accept;
    assign output_reset      = !reset || flush || accept;
    assign counter_enable    = reset && !flush && in_mac;
    // The multiplier register is the last pipe stage; the accumulator follows it.
    assign multiplier_enable = reset && !flush && issue_tap[pipe_depth-1];
    assign output_enable     = reset && !flush && issue_tap[pipe_depth];

endmodule
